// File: rtl/sram22_adapter_pkg.sv
// Shared widths and record types for the sram22 request adapter.
package sram22_adapter_pkg;

  localparam int DATA_WIDTH  = 128;
  localparam int ADDR_WIDTH  = 8;
  localparam int WMASK_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0]  wdata;
  } req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  is_write;
  } rsp_entry_t;

endpackage

// File: rtl/sram22_req_adapter_if.sv
// Request/response bus plus macro pins of the sram22 adapter.
// SRAM_ADPT_WRESP_EN adds rsp_is_write (write responses).
interface sram22_req_adapter_if import sram22_adapter_pkg::*; ();

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_rdata;
`ifdef SRAM_ADPT_WRESP_EN
  logic                   rsp_is_write;
`endif
  logic                   sram_ce;
  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  // Adapter side
  modport slave (
`ifdef SRAM_ADPT_WRESP_EN
    output rsp_is_write,
`endif
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready, sram_dout,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_ce, sram_we, sram_wmask, sram_addr, sram_din
  );

  // Core and macro side
  modport master (
`ifdef SRAM_ADPT_WRESP_EN
    input  rsp_is_write,
`endif
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_ce, sram_we, sram_wmask, sram_addr, sram_din
  );

endinterface

// File: rtl/sram22_rsp_fifo.sv
// Small synchronous FIFO holding stalled responses; async active-low reset
// on control state only, storage is not reset.
module sram22_rsp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Pointer advance and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // Control state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/sram22_req_adapter.sv
// Valid/ready front-end for the sram22_256x128m4w8 macro. Requests drive the
// macro pins combinationally; read data (one cycle later) is either bypassed
// to the response port or parked in a small FIFO. Credits (fifo + in-flight)
// guarantee a parked response always has room.
// SRAM_ADPT_WRESP_EN: writes also take a credit and return a response with
// rsp_is_write=1 and zero data.
module sram22_req_adapter
  import sram22_adapter_pkg::*;
#(
  parameter int RESP_DEPTH = 2
) (
  input  logic clk,
  input  logic rstb,
  sram22_req_adapter_if.slave bus
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  req_t       req;
  rsp_entry_t new_ent;
  rsp_entry_t head;
  rsp_entry_t fifo_dout;
  logic       credit_ok;
  logic       accept;
  logic       rsp_acc;
  logic       inflight_q, inflight_d;
  logic       inflight_wr_q, inflight_wr_d;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;

  // Credit check, accept and the in-flight flag for next cycle
  always_comb begin
    req       = '{we: bus.req_we, addr: bus.req_addr, wmask: bus.req_wmask, wdata: bus.req_wdata};
    occ       = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
    credit_ok = (occ < (CW + 1)'(RESP_DEPTH));
`ifdef SRAM_ADPT_WRESP_EN
    bus.req_ready = rstb & credit_ok;
`else
    bus.req_ready = rstb & (req.we | credit_ok);
`endif
    accept = bus.req_valid & bus.req_ready;
`ifdef SRAM_ADPT_WRESP_EN
    rsp_acc = accept;
`else
    rsp_acc = accept & ~req.we;
`endif
    inflight_d    = rsp_acc;
    inflight_wr_d = rsp_acc & req.we;
  end

  assign bus.sram_ce    = accept;
  assign bus.sram_we    = req.we;
  assign bus.sram_wmask = req.wmask;
  assign bus.sram_addr  = req.addr;
  assign bus.sram_din   = req.wdata;

  // In-flight flag: a response is due from the macro this cycle
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      inflight_q    <= 1'b0;
      inflight_wr_q <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_wr_q <= inflight_wr_d;
    end
  end

  // Response selection: bypass when the FIFO is empty, otherwise FIFO head;
  // park the macro output whenever it cannot complete this cycle, since a
  // read accepted now overwrites dout.
  always_comb begin
    new_ent.rdata    = inflight_wr_q ? '0 : bus.sram_dout;
    new_ent.is_write = inflight_wr_q;
    head             = fifo_empty ? new_ent : fifo_dout;
    bus.rsp_valid    = inflight_q | ~fifo_empty;
    fifo_push        = inflight_q & (~fifo_empty | ~bus.rsp_ready);
    fifo_pop         = ~fifo_empty & bus.rsp_ready;
    bus.rsp_rdata    = head.rdata & {DATA_WIDTH{~head.is_write}};
`ifdef SRAM_ADPT_WRESP_EN
    bus.rsp_is_write = head.is_write;
`endif
  end

  sram22_rsp_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (new_ent),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram22_req_adapter.sv
// Bench for sram22_req_adapter: behavioural macro model, reference memory and
// an ordered queue of expected responses with credit-limited acceptance.
module tb_sram22_req_adapter;
  import sram22_adapter_pkg::*;

  localparam int DEPTH = 2;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  sram22_req_adapter_if bus();

  sram22_req_adapter #(.RESP_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  // Macro model: synchronous, latency-1 read, byte-masked write
  logic [DATA_WIDTH-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (bus.sram_ce) begin
      if (bus.sram_we) begin
        for (int b = 0; b < WMASK_WIDTH; b++)
          if (bus.sram_wmask[b]) sram_mem[bus.sram_addr][b*8 +: 8] <= bus.sram_din[b*8 +: 8];
      end else begin
        bus.sram_dout <= sram_mem[bus.sram_addr];
      end
    end
  end

  typedef struct {
    logic [DATA_WIDTH-1:0] d;
    logic                  w;
  } exp_t;

  logic [DATA_WIDTH-1:0] ref_mem [256];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vld_cnt = 0;
  logic last_acc = 1'b0;

  task automatic check_val(input string tag, input logic [DATA_WIDTH-1:0] got,
                           input logic [DATA_WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at negedge, advance the model at posedge
  task automatic step();
    logic exp_rdy, exp_vld, acc, hs;
    exp_t e;
    @(negedge clk);
`ifdef SRAM_ADPT_WRESP_EN
    exp_rdy = (exp_q.size() < DEPTH);
`else
    exp_rdy = bus.req_we ? 1'b1 : (exp_q.size() < DEPTH);
`endif
    exp_vld = (exp_q.size() > 0);
    check_val("req_ready", bus.req_ready, exp_rdy);
    check_val("rsp_valid", bus.rsp_valid, exp_vld);
    check_val("sram_ce", bus.sram_ce, bus.req_valid & exp_rdy);
    check_val("sram_addr", bus.sram_addr, bus.req_addr);
    if (exp_vld) begin
      check_val("rsp_rdata", bus.rsp_rdata, exp_q[0].d);
`ifdef SRAM_ADPT_WRESP_EN
      check_val("rsp_is_write", bus.rsp_is_write, exp_q[0].w);
`endif
    end
    check_val("fifo_no_ovf", dut.fifo_push & (dut.fifo_count == DEPTH), 1'b0);
    vld_cnt += int'(bus.rsp_valid);
    acc = bus.req_valid & exp_rdy;
    hs  = exp_vld & bus.rsp_ready;
    @(posedge clk);
    if (hs) void'(exp_q.pop_front());
    if (acc) begin
      if (bus.req_we) begin
        for (int b = 0; b < WMASK_WIDTH; b++)
          if (bus.req_wmask[b]) ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
`ifdef SRAM_ADPT_WRESP_EN
        e.d = '0; e.w = 1'b1;
        exp_q.push_back(e);
`endif
      end else begin
        e.d = ref_mem[bus.req_addr]; e.w = 1'b0;
        exp_q.push_back(e);
      end
    end
    last_acc = acc;
    #1;
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic send(input logic we, input logic [ADDR_WIDTH-1:0] addr,
                      input logic [WMASK_WIDTH-1:0] mask, input logic [DATA_WIDTH-1:0] data);
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wmask = mask;
    bus.req_wdata = data;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) check_val("accept_timeout", 1'b0, 1'b1);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i]  = sram_mem[i];
    end
    bus.sram_dout = '0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req_ready", bus.req_ready, 1'b0);
    check_val("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_val("rst_sram_ce", bus.sram_ce, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read-back
    send(1'b1, 8'h10, 16'hFFFF, 128'h0123456789abcdef0123456789abcdef);
    send(1'b0, 8'h10, 16'h0000, '0);
    check_val("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check_val("t1_rdata", bus.rsp_rdata, 128'h0123456789abcdef0123456789abcdef);
    step();

    // Partial write over a 0x55 word
    send(1'b1, 8'h11, 16'hFFFF, {16{8'h55}});
    send(1'b1, 8'h11, 16'h0001, 128'hAA);
    send(1'b0, 8'h11, 16'h0000, '0);
    check_val("t2_rdata", bus.rsp_rdata, {{15{8'h55}}, 8'hAA});
    step();

    // Stalled consumer: only DEPTH reads accepted
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h01, '0, '0);
    send(1'b0, 8'h02, '0, '0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h03;
    repeat (3) step();
    check_val("t3_blocked", last_acc, 1'b0);
    bus.rsp_ready = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    check_val("t3_third_accepted", last_acc, 1'b1);
    bus.req_valid = 1'b0;
    repeat (3) step();

    // Back-to-back reads
    vld_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = ADDR_WIDTH'(8'h40 + i);
      step();
      check_val("t4_accept", last_acc, 1'b1);
    end
    bus.req_valid = 1'b0;
    repeat (2) step();
    check_val("t4_vld_cycles", vld_cnt, 8);

    // Reset right after a read accept
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h05, '0, '0);
    rstb = 1'b0;
    #1;
    check_val("t5_rsp_valid", bus.rsp_valid, 1'b0);
    check_val("t5_req_ready", bus.req_ready, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstb = 1'b1;
    repeat (2) step();
    check_val("t5_occ", dut.occ, 0);
    send(1'b0, 8'h06, '0, '0);
    send(1'b0, 8'h07, '0, '0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h08;
    step();
    check_val("t5_credit_limit", last_acc, 1'b0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();

    // Write then read of the same word
    send(1'b1, 8'h20, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
    send(1'b0, 8'h20, '0, '0);
    repeat (3) step();

    // Randomized traffic, payload held while valid and not accepted
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req_valid || last_acc) begin
        bus.req_valid = ($urandom_range(3) != 0);
        bus.req_we    = ($urandom_range(2) == 0);
        bus.req_addr  = ADDR_WIDTH'($urandom_range(7));
        bus.req_wmask = WMASK_WIDTH'($urandom);
        bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    check_val("drain_empty", bus.rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
